// File: rtl/serial_add_receiver.sv
// serial_add_receiver: receiving end of the LSB-first bit-serial operand link.
// Adds two serial operand streams with a registered carry and reassembles the
// N-bit sum. The result and its carry-out are handed downstream over valid/ready.
//
// Ports:
//   clk, rst        - clock; synchronous active-high reset
//   a_bit, b_bit    - serial operand bits, LSB first
//   bit_valid       - a_bit/b_bit qualified this cycle
//   start           - marks bit 0 of a frame (only with bit_valid)
//   busy            - frame in progress
//   sum, cout       - parallel result of the last completed frame
//   out_valid       - result not yet taken
//   out_ready       - downstream accepts result
//   frame_err       - one-cycle pulse after a frame is aborted by an early start
module serial_add_receiver #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_bit,
    input  logic         b_bit,
    input  logic         bit_valid,
    input  logic         start,
    output logic         busy,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         frame_err
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           carry_q, carry_d;
    logic [N-1:0]   sreg_q, sreg_d;
    logic [N-1:0]   sum_d;
    logic           cout_d;
    logic           out_valid_d;
    logic           frame_err_d;

    logic           accept_start;
    logic           accept_bit;
    logic           carry_in;
    logic           s;
    logic           c_next;
    logic           last;
    logic [N-1:0]   word;

    // Next-state, datapath and registered-output values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        sreg_d      = sreg_q;
        sum_d       = sum;
        cout_d      = cout;
        out_valid_d = out_valid;
        frame_err_d = 1'b0;

        // In DONE a start is only honoured when the result leaves on the same edge
        accept_start = bit_valid && start && ((state_q != DONE) || out_ready);
        accept_bit   = bit_valid && !start && (state_q == SHIFT);

        carry_in = accept_start ? 1'b0 : carry_q;
        s        = a_bit ^ b_bit ^ carry_in;
        c_next   = (a_bit & b_bit) | (a_bit & carry_in) | (b_bit & carry_in);

        // New bit enters at the MSB; a start clears everything below it
        word = accept_start ? N'({s, N'(0)} >> 1) : N'({s, sreg_q} >> 1);
        last = accept_start ? (N == 1) : (cnt_q == CW'(N - 1));

        // Result handoff; may be overridden below by a back-to-back start
        if (state_q == DONE && out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
        end

        if (accept_start || accept_bit) begin
            carry_d = c_next;
            sreg_d  = word;
            if (last) begin
                sum_d       = word;
                cout_d      = c_next;
                out_valid_d = 1'b1;
                cnt_d       = '0;
                state_d     = DONE;
            end else begin
                cnt_d   = accept_start ? CW'(1) : CW'(cnt_q + CW'(1));
                state_d = SHIFT;
            end
        end

        frame_err_d = accept_start && (state_q == SHIFT);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            sreg_q    <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            sreg_q    <= sreg_d;
            sum       <= sum_d;
            cout      <= cout_d;
            out_valid <= out_valid_d;
            busy      <= (state_d == SHIFT);
            frame_err <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_serial_add_receiver.sv
// Bench for serial_add_receiver (N=4): directed frames with hand-computed
// results queued as expectations; a monitor pops one per output handshake.
module tb_serial_add_receiver;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         a_bit = 1'b0;
    logic         b_bit = 1'b0;
    logic         bit_valid = 1'b0;
    logic         start = 1'b0;
    logic         busy;
    logic [N-1:0] sum;
    logic         cout;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         frame_err;

    int           vectors = 0;
    int           miscompares = 0;
    logic [N:0]   exp_q[$];

    serial_add_receiver #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .bit_valid (bit_valid),
        .start     (start),
        .busy      (busy),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge
    task automatic step(input logic bv, input logic st, input logic ab, input logic bb);
        bit_valid = bv;
        start     = st;
        a_bit     = ab;
        b_bit     = bb;
        @(posedge clk);
        #1;
    endtask

    // Full frame; optional stall after bit stall_at; expected result queued before last bit
    task automatic frame(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] exp_sum, input logic exp_cout,
                         input logic exp_err, input int stall_at, input int stall_len);
        for (int i = 0; i < int'(N); i++) begin
            if (i == int'(N) - 1) exp_q.push_back({exp_cout, exp_sum});
            step(1'b1, (i == 0), a[i], b[i]);
            chk("frame_err", 32'(frame_err), (i == 0) ? 32'(exp_err) : 32'd0);
            if (i < int'(N) - 1) begin
                chk("busy_mid", 32'(busy), 32'd1);
            end else begin
                chk("out_valid_done", 32'(out_valid), 32'd1);
                chk("busy_done", 32'(busy), 32'd0);
            end
            if (i == stall_at) begin
                for (int k = 0; k < stall_len; k++) begin
                    step(1'b0, 1'b0, 1'b0, 1'b0);
                    chk("busy_stall", 32'(busy), 32'd1);
                    chk("out_valid_stall", 32'(out_valid), 32'd0);
                end
            end
        end
    endtask

    // Scoreboard monitor: one pop per handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL result_unexpected: got sum=%0d cout=%0d with nothing expected", sum, cout);
            end else begin
                logic [N:0] e;
                e = exp_q.pop_front();
                if ({cout, sum} !== e) begin
                    miscompares++;
                    $display("FAIL result: got sum=%0d cout=%0d expected sum=%0d cout=%0d",
                             sum, cout, e[N-1:0], e[N]);
                end
            end
        end
    end

    initial begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);

        // 5+3 with downstream stalled; start in DONE without ready is ignored
        out_ready = 1'b0;
        frame(4'd5, 4'd3, 4'd8, 1'b0, 1'b0, -1, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("hold_valid", 32'(out_valid), 32'd1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("done_start_ignored_err", 32'(frame_err), 32'd0);
        chk("done_start_ignored_busy", 32'(busy), 32'd0);
        chk("done_start_ignored_valid", 32'(out_valid), 32'd1);
        chk("hold_sum", 32'(sum), 32'd8);
        out_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("handoff_valid", 32'(out_valid), 32'd0);
        chk("sum_retained", 32'(sum), 32'd8);

        // Back-to-back frames with ready held high
        frame(4'd15, 4'd1, 4'd0, 1'b1, 1'b0, -1, 0);
        frame(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, -1, 0);
        frame(4'd3, 4'd4, 4'd7, 1'b0, 1'b0, -1, 0);
        frame(4'd8, 4'd8, 4'd0, 1'b1, 1'b0, -1, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_after_b2b", 32'(out_valid), 32'd0);

        // 9+6 with a 3-cycle stall between bits 1 and 2
        frame(4'd9, 4'd6, 4'd15, 1'b0, 1'b0, 1, 3);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // 7+7 aborted after 2 bits by a new 2+2 frame
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        frame(4'd2, 4'd2, 4'd4, 1'b0, 1'b1, -1, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during bit 2 of a 1+1 frame, then a clean 1+1 frame
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_err", 32'(frame_err), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst_idle", 32'(busy), 32'd0);
        frame(4'd1, 4'd1, 4'd2, 1'b0, 1'b0, -1, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        chk("results_outstanding", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
